// File: rtl/keypad_pkg.sv
// Shared state encodings and column-decode helpers for the hex keypad writer.
package keypad_pkg;

  localparam logic [3:0] KEY_COLS_IDLE = 4'hF;
  localparam logic [2:0] MAX_DIGITS    = 3'd4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } write_state_t;

  // A genuine key pulls exactly one column low; anything else is a ghost or idle.
  function automatic logic single_low(input logic [3:0] cols);
    case (cols)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] cols);
    case (cols)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner for a 4x4 keypad: synchronises the columns, debounces press and
// release, and emits a one-cycle pulse with {row, column} for each accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int          SCAN_DIV_W      = 18,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam logic [19:0] DEB_LAST = DEBOUNCE_CYCLES - 20'd1;

  logic [3:0]            col_meta;
  logic [3:0]            col_s;
  logic [3:0]            col_lat;
  logic [1:0]            row_idx;
  logic [SCAN_DIV_W-1:0] div_cnt;
  logic [19:0]           deb_cnt;
  scan_state_t           state;
  scan_state_t           state_next;
  logic                  cols_idle;
  logic                  cols_stable;
  logic                  deb_done;
  logic                  start_debounce;
  logic                  accept;
  logic                  release_done;

  assign key_row     = ~(4'b0001 << row_idx);
  assign cols_idle   = (col_s == KEY_COLS_IDLE);
  assign cols_stable = (col_s == col_lat);
  assign deb_done    = (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= KEY_COLS_IDLE;
      col_s    <= KEY_COLS_IDLE;
    end else begin
      col_meta <= key_col;
      col_s    <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    start_debounce = 1'b0;
    accept         = 1'b0;
    release_done   = 1'b0;
    case (state)
      SCAN: begin
        if (!cols_idle) begin
          start_debounce = 1'b1;
          state_next     = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!cols_stable) begin
          state_next = SCAN;
        end else if (deb_done) begin
          accept     = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (cols_idle && deb_done) begin
          release_done = 1'b1;
          state_next   = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // The row stays frozen from detection until release so keyCode names the pressed row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx   <= 2'd0;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      col_lat   <= KEY_COLS_IDLE;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          deb_cnt <= '0;
          if (start_debounce) begin
            col_lat <= col_s;
          end else begin
            div_cnt <= div_cnt + SCAN_DIV_W'(1);
            if (&div_cnt) row_idx <= row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (accept || !cols_stable) deb_cnt <= '0;
          else                        deb_cnt <= deb_cnt + 20'd1;
          if (accept && single_low(col_lat)) begin
            key_valid <= 1'b1;
            key_code  <= {row_idx, low_index(col_lat)};
          end
        end
        HELD: begin
          if (release_done) begin
            deb_cnt <= '0;
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
          end else if (cols_idle) begin
            deb_cnt <= deb_cnt + 20'd1;
          end else begin
            deb_cnt <= '0;
          end
        end
        default: deb_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/hex_keypad_writer.sv
// Keypad entry path: collects hex nibbles into a 16-bit word and writes it to
// data memory at an auto-incrementing address when the commit button is pressed.
module hex_keypad_writer
  import keypad_pkg::*;
#(
  parameter int          SCAN_DIV_W      = 18,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int          ADDR_W          = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [3:0]        KeyCol,
  input  logic              BtnCommit,
  input  logic              BtnClear,
  input  logic              wrReady,
  output logic [3:0]        KeyRow,
  output logic              keyValid,
  output logic [3:0]        keyCode,
  output logic [15:0]       entryData,
  output logic [2:0]        digitCount,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [15:0]       wrData
);

  logic [1:0]   commit_sync;
  logic [1:0]   clear_sync;
  logic         commit_prev;
  logic         clear_prev;
  logic         commit_edge;
  logic         clear_edge;
  write_state_t wr_state;
  write_state_t wr_next;
  logic         start_write;
  logic         finish_write;
  logic         clear_entry;
  logic         take_key;

  keypad_scanner #(
    .SCAN_DIV_W     (SCAN_DIV_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk      (Clk),
    .rst_n    (reset),
    .key_col  (KeyCol),
    .key_row  (KeyRow),
    .key_valid(keyValid),
    .key_code (keyCode)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      commit_sync <= 2'b00;
      clear_sync  <= 2'b00;
      commit_prev <= 1'b0;
      clear_prev  <= 1'b0;
    end else begin
      commit_sync <= {commit_sync[0], BtnCommit};
      clear_sync  <= {clear_sync[0], BtnClear};
      commit_prev <= commit_sync[1];
      clear_prev  <= clear_sync[1];
    end
  end

  assign commit_edge = commit_sync[1] & ~commit_prev;
  assign clear_edge  = clear_sync[1] & ~clear_prev;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) wr_state <= IDLE;
    else        wr_state <= wr_next;
  end

  // Clear outranks both a new key and a commit; in WRITE every user input is ignored.
  always_comb begin
    wr_next      = wr_state;
    start_write  = 1'b0;
    finish_write = 1'b0;
    clear_entry  = 1'b0;
    take_key     = 1'b0;
    case (wr_state)
      IDLE: begin
        if (clear_edge) begin
          clear_entry = 1'b1;
        end else begin
          take_key = keyValid;
          if (commit_edge && (digitCount != 3'd0)) begin
            start_write = 1'b1;
            wr_next     = WRITE;
          end
        end
      end
      WRITE: begin
        if (wrReady) begin
          finish_write = 1'b1;
          wr_next      = IDLE;
        end
      end
      default: wr_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      entryData  <= 16'd0;
      digitCount <= 3'd0;
    end else if (clear_entry || finish_write) begin
      entryData  <= 16'd0;
      digitCount <= 3'd0;
    end else if (take_key) begin
      entryData <= {entryData[11:0], keyCode};
      if (digitCount != MAX_DIGITS) digitCount <= digitCount + 3'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrData <= 16'd0;
    end else if (start_write) begin
      wrEn   <= 1'b1;
      wrData <= entryData;
    end else if (finish_write) begin
      wrEn   <= 1'b0;
      wrAddr <= wrAddr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_hex_keypad_writer.sv
// Directed bench for hex_keypad_writer with a queue-based entry/write model and
// a per-cycle compare process on the falling clock edge.
module tb_hex_keypad_writer;

  localparam int          SCAN_DIV_W      = 2;
  localparam logic [19:0] DEBOUNCE_CYCLES = 20'd4;
  localparam int          ADDR_W          = 8;
  localparam int          ADDR_SPAN       = 1 << ADDR_W;

  logic              Clk       = 1'b0;
  logic              reset     = 1'b0;
  logic [3:0]        KeyCol;
  logic              BtnCommit = 1'b0;
  logic              BtnClear  = 1'b0;
  logic              wrReady   = 1'b0;
  logic [3:0]        KeyRow;
  logic              keyValid;
  logic [3:0]        keyCode;
  logic [15:0]       entryData;
  logic [2:0]        digitCount;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [15:0]       wrData;

  // Physical keypad: a pressed key pulls its columns low only while its row is driven.
  logic       press_on    = 1'b0;
  logic [1:0] press_row   = 2'd0;
  logic [3:0] press_cols  = 4'hF;
  logic       bounce_on   = 1'b0;
  logic [3:0] bounce_cols = 4'hF;

  assign KeyCol = bounce_on ? bounce_cols :
                  (press_on && (KeyRow == ~(4'b0001 << press_row))) ? press_cols : 4'hF;

  hex_keypad_writer #(
    .SCAN_DIV_W     (SCAN_DIV_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ADDR_W         (ADDR_W)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .KeyCol    (KeyCol),
    .BtnCommit (BtnCommit),
    .BtnClear  (BtnClear),
    .wrReady   (wrReady),
    .KeyRow    (KeyRow),
    .keyValid  (keyValid),
    .keyCode   (keyCode),
    .entryData (entryData),
    .digitCount(digitCount),
    .wrEn      (wrEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData)
  );

  always #5 Clk = ~Clk;

  logic [3:0]  digits[$];
  int          writes_done   = 0;
  logic [15:0] pending_word  = 16'd0;
  logic        settled       = 1'b0;
  logic        key_allowed   = 1'b0;
  logic        write_allowed = 1'b0;
  logic [3:0]  expect_code   = 4'd0;
  int          key_pulses    = 0;
  int          wr_high       = 0;
  logic [15:0] last_wr_data  = 16'd0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] model_entry();
    logic [15:0] w;
    w = 16'd0;
    foreach (digits[i]) w = {w[11:0], digits[i]};
    return w;
  endfunction

  function automatic logic [3:0] col_pattern(input logic [3:0] code);
    return ~(4'b0001 << code[1:0]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic applyStimulus(input logic commit, input logic clear);
    BtnCommit = commit;
    BtnClear  = clear;
    tick(1);
    BtnCommit = 1'b0;
    BtnClear  = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] code, input logic [3:0] cols,
                           input logic valid, input int hold);
    int seen;
    settled     = 1'b0;
    expect_code = code;
    key_allowed = valid;
    seen        = key_pulses;
    press_row   = code[3:2];
    press_cols  = cols;
    press_on    = 1'b1;
    tick(hold);
    press_on = 1'b0;
    tick(16);
    key_allowed = 1'b0;
    checkOutput("keyValid pulses per press", key_pulses - seen, valid ? 1 : 0);
    if (valid) begin
      digits.push_back(code);
      if (digits.size() > 4) void'(digits.pop_front());
    end
    settled = 1'b1;
  endtask

  task automatic commit_entry(input logic expect_write, input int ready_delay);
    int high_before;
    int guard;
    high_before   = wr_high;
    settled       = 1'b0;
    pending_word  = model_entry();
    write_allowed = expect_write;
    wrReady       = expect_write && (ready_delay == 0);
    applyStimulus(1'b1, 1'b0);
    if (expect_write) begin
      guard = 0;
      while (!wrEn && guard < 20) begin
        tick(1);
        guard++;
      end
      checkOutput("wrEn rises on commit", wrEn, 1'b1);
      if (ready_delay > 0) begin
        tick(ready_delay);
        wrReady = 1'b1;
      end
      tick(1);
      wrReady = 1'b0;
    end
    tick(8);
    checkOutput("wrEn high cycles", wr_high - high_before,
                expect_write ? ready_delay + 1 : 0);
    write_allowed = 1'b0;
    if (expect_write) begin
      writes_done++;
      digits.delete();
    end
    settled = 1'b1;
  endtask

  // Per-cycle comparison against the model while the design is out of reset.
  always @(negedge Clk) begin
    if (reset) begin
      checkOutput("KeyRow one-cold", $countones(~KeyRow), 1);
      if (keyValid) begin
        key_pulses++;
        checkOutput("keyValid expected", key_allowed, 1'b1);
        checkOutput("keyCode on pulse", keyCode, expect_code);
      end
      if (wrEn) begin
        wr_high++;
        last_wr_data = wrData;
        last_wr_addr = wrAddr;
        checkOutput("wrEn expected", write_allowed, 1'b1);
        checkOutput("wrData while wrEn", wrData, pending_word);
        checkOutput("wrAddr while wrEn", wrAddr, writes_done % ADDR_SPAN);
      end
      if (settled) begin
        checkOutput("entryData idle", entryData, model_entry());
        checkOutput("digitCount idle", digitCount, digits.size());
        checkOutput("wrAddr idle", wrAddr, writes_done % ADDR_SPAN);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] seq3 [5];
  int seen_main;
  int guard;

  initial begin
    seq3 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

    #1;
    checkOutput("reset KeyRow", KeyRow, 4'b1110);
    checkOutput("reset keyValid", keyValid, 1'b0);
    checkOutput("reset keyCode", keyCode, 4'h0);
    checkOutput("reset entryData", entryData, 16'h0000);
    checkOutput("reset digitCount", digitCount, 3'd0);
    checkOutput("reset wrEn", wrEn, 1'b0);
    checkOutput("reset wrAddr", wrAddr, 0);
    checkOutput("reset wrData", wrData, 16'h0000);
    tick(3);
    reset   = 1'b1;
    settled = 1'b1;
    tick(2);

    // Single key on row 2, column 1.
    press_key(4'h9, 4'b1101, 1'b1, 30);
    checkOutput("t1 keyCode", keyCode, 4'h9);
    checkOutput("t1 entryData", entryData, 16'h0009);
    checkOutput("t1 digitCount", digitCount, 3'd1);

    // Bouncing column must never be accepted.
    settled     = 1'b0;
    key_allowed = 1'b0;
    seen_main   = key_pulses;
    bounce_on   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bounce_cols = i[0] ? 4'hF : 4'b1101;
      tick(2);
    end
    bounce_on   = 1'b0;
    bounce_cols = 4'hF;
    tick(16);
    checkOutput("t2 bounce pulses", key_pulses - seen_main, 0);
    checkOutput("t2 entryData", entryData, 16'h0009);
    settled = 1'b1;

    // Five keys saturate the entry; a ghost pattern is rejected.
    for (int i = 0; i < 5; i++) press_key(seq3[i], col_pattern(seq3[i]), 1'b1, 30);
    checkOutput("t3 entryData", entryData, 16'h2345);
    checkOutput("t3 digitCount", digitCount, 3'd4);
    press_key(4'h4, 4'b1001, 1'b0, 30);
    checkOutput("t3 ghost entryData", entryData, 16'h2345);
    checkOutput("t3 ghost keyCode", keyCode, 4'h5);

    // Commit held off by wrReady, then an empty commit.
    commit_entry(1'b1, 3);
    checkOutput("t4 wrData", last_wr_data, 16'h2345);
    checkOutput("t4 write addr", last_wr_addr, 0);
    checkOutput("t4 wrAddr after", wrAddr, 1);
    checkOutput("t4 entryData after", entryData, 16'h0000);
    checkOutput("t4 digitCount after", digitCount, 3'd0);
    checkOutput("t4 wrEn after", wrEn, 1'b0);
    commit_entry(1'b0, 0);
    checkOutput("t4 empty commit wrAddr", wrAddr, 1);

    // Clear and commit together: clear wins, nothing written.
    press_key(4'hA, col_pattern(4'hA), 1'b1, 30);
    press_key(4'hB, col_pattern(4'hB), 1'b1, 30);
    checkOutput("t5 digitCount before clear", digitCount, 3'd2);
    seen_main     = wr_high;
    settled       = 1'b0;
    write_allowed = 1'b0;
    applyStimulus(1'b1, 1'b1);
    tick(10);
    digits.delete();
    settled = 1'b1;
    checkOutput("t5 clear+commit wrEn cycles", wr_high - seen_main, 0);
    checkOutput("t5 clear entryData", entryData, 16'h0000);

    // Walk the address up to 255 and write across the wrap.
    for (int n = 0; n < 300 && (writes_done % ADDR_SPAN) != ADDR_SPAN - 1; n++) begin
      press_key(n[3:0], col_pattern(n[3:0]), 1'b1, 30);
      commit_entry(1'b1, 0);
    end
    checkOutput("t5 wrAddr preloaded", wrAddr, 255);
    press_key(4'h7, col_pattern(4'h7), 1'b1, 30);
    commit_entry(1'b1, 0);
    checkOutput("t5 write at 255", last_wr_addr, 255);
    checkOutput("t5 wrData at 255", last_wr_data, 16'h0007);
    checkOutput("t5 wrAddr wrapped", wrAddr, 0);

    // Reset during a pending write while a key is being debounced.
    press_key(4'h6, col_pattern(4'h6), 1'b1, 30);
    settled       = 1'b0;
    pending_word  = model_entry();
    write_allowed = 1'b1;
    wrReady       = 1'b0;
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (!wrEn && guard < 20) begin tick(1); guard++; end
    checkOutput("t6 wrEn pending", wrEn, 1'b1);
    guard = 0;
    while (KeyRow == 4'b1110 && guard < 20) begin tick(1); guard++; end
    guard = 0;
    while (KeyRow != 4'b1110 && guard < 20) begin tick(1); guard++; end
    checkOutput("t6 row 0 reached", KeyRow, 4'b1110);
    key_allowed = 1'b0;
    press_row   = 2'd0;
    press_cols  = 4'b1011;
    press_on    = 1'b1;
    tick(4);
    checkOutput("t6 wrEn before reset", wrEn, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("t6 reset wrEn", wrEn, 1'b0);
    checkOutput("t6 reset KeyRow", KeyRow, 4'b1110);
    checkOutput("t6 reset keyValid", keyValid, 1'b0);
    checkOutput("t6 reset keyCode", keyCode, 4'h0);
    checkOutput("t6 reset entryData", entryData, 16'h0000);
    checkOutput("t6 reset digitCount", digitCount, 3'd0);
    checkOutput("t6 reset wrAddr", wrAddr, 0);
    checkOutput("t6 reset wrData", wrData, 16'h0000);
    press_on      = 1'b0;
    write_allowed = 1'b0;
    digits.delete();
    writes_done = 0;
    tick(2);
    reset = 1'b1;
    #1;
    checkOutput("t6 KeyRow after release", KeyRow, 4'b1110);
    settled = 1'b1;
    tick(2);
    checkOutput("t6 KeyRow dwell", KeyRow, 4'b1110);
    press_key(4'h9, 4'b1101, 1'b1, 30);
    checkOutput("t6 entryData after restart", entryData, 16'h0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
